// File: rtl/avalon_gpio_port_pkg.sv
// Shared constants for the Avalon-MM GPIO port: register addresses, edge modes,
// and a helper that zero-extends a register to the 32-bit bus.
package gpio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic [31:0] zext32(input logic [31:0] val, input int unsigned width);
    if (width >= 32) return val;
    return val & ((32'h1 << width) - 32'h1);
  endfunction

endpackage

// File: rtl/avalon_gpio_port_if.sv
// Avalon-MM slave bus bundle for the GPIO port.
interface avalon_gpio_port_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/gpio_edge_sync.sv
// Pin synchroniser, previous-value register and armed edge-pulse generation.
// Arming keeps pins that are high across reset release from faking an edge.
module gpio_edge_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int CW         = $clog2(ARM_CYCLES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [CW-1:0]    arm_cnt_q, arm_cnt_d;
  logic             armed;
  logic [WIDTH-1:0] edge_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q    <= '0;
      arm_cnt_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q    <= sync_q[SYNC_STAGES-1];
      arm_cnt_q <= arm_cnt_d;
    end
  end

  // Saturating count; armed once the sync and prev flops all hold real pin data.
  assign armed     = (arm_cnt_q == CW'(ARM_CYCLES));
  assign arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + CW'(1);
  assign sync_in   = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      EDGE_FALL: edge_raw = ~sync_in & prev_q;
      EDGE_ANY:  edge_raw = sync_in ^ prev_q;
      default:   edge_raw = sync_in & ~prev_q;
    endcase
  end

  assign edge_pulse = armed ? edge_raw : '0;

endmodule

// File: rtl/avalon_gpio_port.sv
// Avalon-MM GPIO slave: register file, registered read mux and level IRQ.
// Edge capture sets win over a same-cycle write-1-clear.
module avalon_gpio_port
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  avalon_gpio_port_if.slave   bus,
  input  logic [WIDTH-1:0]    in_port,
  output logic [WIDTH-1:0]    out_port,
  output logic [WIDTH-1:0]    oe_port,
  output logic                irq
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] sync_in, edge_pulse;
  logic [WIDTH-1:0] wdata, clr_mask;
  logic             wr;

  gpio_edge_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_edge_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .sync_in    (sync_in),
    .edge_pulse (edge_pulse)
  );

  assign wr    = bus.chipselect && !bus.write_n;
  assign wdata = bus.writedata[WIDTH-1:0];

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irqmask_d  = irqmask_q;
    clr_mask   = '0;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:    data_out_d = wdata;
        ADDR_DIR:     dir_d      = wdata;
        ADDR_IRQMASK: irqmask_d  = wdata;
        ADDR_EDGECAP: clr_mask   = wdata;
        ADDR_OUTSET:  data_out_d = data_out_q | wdata;
        ADDR_OUTCLR:  data_out_d = data_out_q & ~wdata;
        default: ;
      endcase
    end
    edgecap_d = (edgecap_q & ~clr_mask) | edge_pulse;
  end

  always_comb begin
    rdata_d = '0;
    case (bus.address)
      ADDR_DATA:    rdata_d = zext32(32'((sync_in & ~dir_q) | (data_out_q & dir_q)), WIDTH);
      ADDR_DIR:     rdata_d = zext32(32'(dir_q), WIDTH);
      ADDR_IRQMASK: rdata_d = zext32(32'(irqmask_q), WIDTH);
      ADDR_EDGECAP: rdata_d = zext32(32'(edgecap_q), WIDTH);
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_OUT;
      dir_q      <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      rdata_q    <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign out_port     = data_out_q;
  assign oe_port      = dir_q;
  assign irq          = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_avalon_gpio_port.sv
// Directed bench for avalon_gpio_port: WIDTH=16, two sync stages, rising edges.
module tb_avalon_gpio_port;
  import gpio_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [15:0] in_port;
  logic [15:0] out_port;
  logic [15:0] oe_port;
  logic        irq;
  int          passed;
  int          total;

  avalon_gpio_port_if bus ();

  avalon_gpio_port #(
    .WIDTH       (16),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (EDGE_RISE),
    .RESET_OUT   (16'h00A5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .in_port  (in_port),
    .out_port (out_port),
    .oe_port  (oe_port),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    @(negedge clk);
    d = bus.readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1;
    total++; if (bus.readdata !== 32'h0) $display("FAIL rst_readdata got=%h exp=%h", bus.readdata, 32'h0); else passed++;
    @(negedge clk); reset_n = 1'b1;
    total++; if (out_port !== 16'h00A5) $display("FAIL rst_out_port got=%h exp=%h", out_port, 16'h00A5); else passed++;
    total++; if (oe_port !== 16'h0000) $display("FAIL rst_oe_port got=%h exp=%h", oe_port, 16'h0); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL rst_irq got=%b exp=0", irq); else passed++;
    bus_read(ADDR_DIR, d);
    total++; if (d !== 32'h0) $display("FAIL rst_dir got=%h exp=%h", d, 32'h0); else passed++;
    bus_read(ADDR_IRQMASK, d);
    total++; if (d !== 32'h0) $display("FAIL rst_irqmask got=%h exp=%h", d, 32'h0); else passed++;
    bus_read(ADDR_EDGECAP, d);
    total++; if (d !== 32'h0) $display("FAIL rst_edgecap got=%h exp=%h", d, 32'h0); else passed++;
  endtask

  task automatic test_set_clr();
    logic [31:0] d;
    bus_write(ADDR_DATA, 32'hFFFF_1234);
    total++; if (out_port !== 16'h1234) $display("FAIL data_write got=%h exp=%h", out_port, 16'h1234); else passed++;
    bus_write(ADDR_OUTSET, 32'h0000_0F00);
    total++; if (out_port !== 16'h1F34) $display("FAIL outset got=%h exp=%h", out_port, 16'h1F34); else passed++;
    bus_write(ADDR_OUTCLR, 32'h0000_0034);
    total++; if (out_port !== 16'h1F00) $display("FAIL outclr got=%h exp=%h", out_port, 16'h1F00); else passed++;
    bus_write(ADDR_DIR, 32'h0000_FFFF);
    total++; if (oe_port !== 16'hFFFF) $display("FAIL oe_all got=%h exp=%h", oe_port, 16'hFFFF); else passed++;
    bus_read(ADDR_DATA, d);
    total++; if (d !== 32'h0000_1F00) $display("FAIL data_read_out got=%h exp=%h", d, 32'h0000_1F00); else passed++;
    bus_read(ADDR_OUTSET, d);
    total++; if (d !== 32'h0) $display("FAIL outset_read got=%h exp=%h", d, 32'h0); else passed++;
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, d);
    total++; if (d !== 32'h0) $display("FAIL reserved_read got=%h exp=%h", d, 32'h0); else passed++;
    total++; if (out_port !== 16'h1F00) $display("FAIL reserved_nowrite got=%h exp=%h", out_port, 16'h1F00); else passed++;
  endtask

  task automatic test_read_mix();
    logic [31:0] d;
    bus_write(ADDR_DIR, 32'h0000_00FF);
    in_port = 16'hAB00;
    bus_write(ADDR_DATA, 32'h0000_00CD);
    idle(3);
    bus_read(ADDR_DATA, d);
    total++; if (d !== 32'h0000_ABCD) $display("FAIL data_mix got=%h exp=%h", d, 32'h0000_ABCD); else passed++;
    bus_read(ADDR_EDGECAP, d);
    total++; if (d !== 32'h0000_AB00) $display("FAIL mix_edgecap got=%h exp=%h", d, 32'h0000_AB00); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL masked_irq got=%b exp=0", irq); else passed++;
    bus_write(ADDR_EDGECAP, 32'h0000_FFFF);
    bus_read(ADDR_EDGECAP, d);
    total++; if (d !== 32'h0) $display("FAIL cap_clear_all got=%h exp=%h", d, 32'h0); else passed++;
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    bus_write(ADDR_IRQMASK, 32'h0000_0008);
    in_port = 16'hAB08;
    @(negedge clk); @(negedge clk);
    total++; if (irq !== 1'b0) $display("FAIL irq_early got=%b exp=0", irq); else passed++;
    @(negedge clk);
    total++; if (irq !== 1'b1) $display("FAIL irq_rise got=%b exp=1", irq); else passed++;
    bus_read(ADDR_EDGECAP, d);
    total++; if (d !== 32'h0000_0008) $display("FAIL cap_bit3 got=%h exp=%h", d, 32'h0000_0008); else passed++;
    @(negedge clk);
    bus.address = ADDR_EDGECAP; bus.writedata = 32'h0000_0008;
    bus.chipselect = 1'b1; bus.write_n = 1'b0;
    #1;
    total++; if (irq !== 1'b1) $display("FAIL irq_hold got=%b exp=1", irq); else passed++;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    total++; if (irq !== 1'b0) $display("FAIL irq_clear got=%b exp=0", irq); else passed++;
    in_port = 16'hAB00;
    idle(5);
    bus_read(ADDR_EDGECAP, d);
    total++; if (d !== 32'h0) $display("FAIL fall_ignored got=%h exp=%h", d, 32'h0); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL fall_irq got=%b exp=0", irq); else passed++;
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    in_port = 16'hAB20;
    idle(4);
    in_port = 16'hAB00;
    idle(4);
    bus_read(ADDR_EDGECAP, d);
    total++; if (d !== 32'h0000_0020) $display("FAIL pre_bit5 got=%h exp=%h", d, 32'h0000_0020); else passed++;
    @(negedge clk);
    in_port = 16'hAB20;
    @(negedge clk);
    @(negedge clk);
    bus.address = ADDR_EDGECAP; bus.writedata = 32'h0000_0020;
    bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus_read(ADDR_EDGECAP, d);
    total++; if (d !== 32'h0000_0020) $display("FAIL set_wins got=%h exp=%h", d, 32'h0000_0020); else passed++;
    bus_write(ADDR_EDGECAP, 32'h0000_0020);
    bus_read(ADDR_EDGECAP, d);
    total++; if (d !== 32'h0) $display("FAIL clr_no_edge got=%h exp=%h", d, 32'h0); else passed++;
  endtask

  task automatic test_reset_cases();
    logic [31:0] d;
    @(negedge clk);
    reset_n = 1'b0;
    in_port = 16'hFFFF;
    idle(2);
    reset_n = 1'b1;
    idle(10);
    bus_read(ADDR_EDGECAP, d);
    total++; if (d !== 32'h0) $display("FAIL static_high got=%h exp=%h", d, 32'h0); else passed++;
    bus_write(ADDR_DATA, 32'h0000_5555);
    bus_write(ADDR_DIR, 32'h0000_00F0);
    bus_write(ADDR_IRQMASK, 32'h0000_00FF);
    bus_read(ADDR_DIR, d);
    total++; if (d !== 32'h0000_00F0) $display("FAIL pre_rst_dir got=%h exp=%h", d, 32'h0000_00F0); else passed++;
    @(negedge clk);
    bus.address = ADDR_DATA; bus.writedata = 32'h0000_FFFF;
    bus.chipselect = 1'b1; bus.write_n = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    total++; if (out_port !== 16'h00A5) $display("FAIL midwr_out got=%h exp=%h", out_port, 16'h00A5); else passed++;
    total++; if (oe_port !== 16'h0000) $display("FAIL midwr_oe got=%h exp=%h", oe_port, 16'h0); else passed++;
    total++; if (bus.readdata !== 32'h0) $display("FAIL midwr_rdata got=%h exp=%h", bus.readdata, 32'h0); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL midwr_irq got=%b exp=0", irq); else passed++;
    reset_n = 1'b1;
    bus_read(ADDR_IRQMASK, d);
    total++; if (d !== 32'h0) $display("FAIL midwr_mask got=%h exp=%h", d, 32'h0); else passed++;
    idle(6);
    bus_read(ADDR_EDGECAP, d);
    total++; if (d !== 32'h0) $display("FAIL midwr_cap got=%h exp=%h", d, 32'h0); else passed++;
  endtask

  initial begin
    passed         = 0;
    total          = 0;
    reset_n        = 1'b0;
    in_port        = 16'h0000;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    test_reset();
    test_set_clr();
    test_read_mix();
    test_edge_irq();
    test_set_wins();
    test_reset_cases();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
